h_bound_judge: RTL and testbench
================================

# h_bound_judge

Downstream control and decision stage for the hint-vector bound check. It sequences one signature's worth of 8-coefficient beats through the h bound-check stage and clears that stage and its accumulator before each run. After the accumulator pipeline drains, it samples the squared-norm total and the running infinity-norm maximum. It then issues a registered accept/reject verdict with per-cause flags to the signing controller.

## Interface
Parameters:
- N_BEATS, 64, beats (8 coefficients each) per signature; ≥ 2
- DRAIN_CYC, 3, cycles waited after the last beat before sampling; must be ≥ 1 + accumulator latency
- ACC_W, 15, width of the accumulated squared norm
- B22, 2048, inclusive L2² bound; pass requires norm ≤ B22
- BOO, 2, inclusive L∞ bound; pass requires hoo ≤ BOO

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a run
- in_flag  in  1  beat-valid, same signal that drives the h stage
- accu_in  in  ACC_W  accumulator output (squared norm)
- hoo_in  in  2  sticky infinity-norm max from the h stage
- stage_clr  out  1  clear pulse OR'd into the h stage reset and the accumulator SCLR
- busy  out  1  high from CLEAR through CMP
- done  out  1  one-cycle verdict strobe
- pass  out  1  verdict, held until the next start
- l2_fail, linf_fail, ovf, proto_err  out  1 each  cause flags, held with pass
- norm_q  out  ACC_W  sampled accu_in, held with pass

## Operation
- States: IDLE → CLEAR → COLLECT → DRAIN → CMP → DONE → IDLE.
- IDLE: start=1 → CLEAR, and all held results (pass, flags, norm_q) clear to 0.
- CLEAR, one cycle: stage_clr=1. Any in_flag here sets proto_err and is not counted.
- COLLECT: a beat counter (width clog2(N_BEATS)) increments on in_flag. When in_flag arrives with count = N_BEATS-1, the state moves to DRAIN and the counter resets to 0.
- DRAIN: a down-counter runs for DRAIN_CYC cycles, then the state moves to CMP. Any in_flag here sets proto_err.
- Overflow tracking, during COLLECT and DRAIN: a previous-accu register is kept. If accu_in < the previous value, ovf is set (the accumulator wrapped).
- CMP, one cycle, everything registered:
  - norm_q ← accu_in
  - l2_fail ← accu_in > B22
  - linf_fail ← hoo_in > BOO
  - pass ← !(l2_fail | linf_fail | ovf | proto_err)
- DONE, one cycle: done=1, then IDLE.
- start outside IDLE is ignored; it does not restart the run.
- Comparisons are unsigned at ACC_W bits and 2 bits respectively.

## Timing
- Reset: state=IDLE, and every output (stage_clr, busy, done, pass, all flags, norm_q) is 0.
- rst mid-run aborts the run immediately: the state returns to IDLE, no done pulse, all outputs 0.
- start sampled at edge of cycle t: stage_clr=1 and busy=1 in t+1, COLLECT from t+2.
- Last beat in cycle f: DRAIN covers f+1..f+DRAIN_CYC, CMP is f+DRAIN_CYC+1, and done=1 in f+DRAIN_CYC+2 with pass, flags and norm_q already valid in that cycle.
- Gaps between beats (in_flag low) are allowed in COLLECT; the counter holds.
- busy falls in the DONE cycle. start in the DONE cycle is ignored; start is accepted from the next IDLE cycle.
- A start in IDLE on the same cycle as an in_flag: the beat is not counted. If it lands in CLEAR, proto_err is set.
- Exactly N_BEATS beats are consumed per run; there is no timeout.

## Test plan
Bench overrides: N_BEATS=4, DRAIN_CYC=3, B22=100, BOO=2.
- Nominal pass: start, then 4 beats with the accu model ending at 40 and hoo=1 → done 5 cycles after the last beat, pass=1, norm_q=40, all flags 0.
- L2 boundary: final accu 100 → pass=1. Repeat with final accu 101 → pass=0, l2_fail=1.
- L∞ fail: hoo_in=3 with accu 20 → pass=0, linf_fail=1, l2_fail=0.
- Overflow: accu sequence 32760, 32767, 5 → ovf=1, pass=0.
- Protocol violations:
  - in_flag during CLEAR → proto_err=1, and the run still needs 4 COLLECT beats.
  - An extra beat during DRAIN → proto_err=1.
  - start asserted during COLLECT → no effect on the beat count.
- Reset mid-run: assert rst in DRAIN → no done pulse, outputs 0. A fresh start then completes normally, stage_clr pulses once, pass=1.

Source files
------------

// File: rtl/h_bound_judge.sv
// h_bound_judge
// Control and decision stage for the hint-vector bound check. Sequences one
// signature (N_BEATS beats of 8 coefficients) through the h bound-check stage,
// clears that stage and its accumulator before the run, waits for the
// accumulator pipeline to drain, then issues a registered accept/reject
// verdict with per-cause flags.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        one-cycle run request (honoured only in IDLE)
//   in_flag      beat-valid shared with the h stage
//   accu_in      accumulated squared norm (ACC_W bits)
//   hoo_in       sticky infinity-norm maximum from the h stage
//   stage_clr    clear pulse for the h stage and the accumulator
//   busy         high from CLEAR through CMP
//   done         one-cycle verdict strobe
//   pass         verdict, held until the next start
//   l2_fail, linf_fail, ovf, proto_err   cause flags, held with pass
//   norm_q       sampled accu_in, held with pass
module h_bound_judge #(
  parameter int N_BEATS   = 64,
  parameter int DRAIN_CYC = 3,
  parameter int ACC_W     = 15,
  parameter int B22       = 2048,
  parameter int BOO       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_flag,
  input  logic [ACC_W-1:0] accu_in,
  input  logic [1:0]       hoo_in,
  output logic             stage_clr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             l2_fail,
  output logic             linf_fail,
  output logic             ovf,
  output logic             proto_err,
  output logic [ACC_W-1:0] norm_q
);

  localparam int CNT_W = $clog2(N_BEATS);
  localparam int DRN_W = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(N_BEATS - 1);
  localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DRAIN_CYC - 1);
  localparam logic [ACC_W-1:0] B22_V      = ACC_W'(B22);
  localparam logic [1:0]       BOO_V      = 2'(BOO);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    COLLECT = 3'd2,
    DRAIN   = 3'd3,
    CMP     = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] beat_cnt_r;
  logic [DRN_W-1:0] drain_cnt_r;
  logic [ACC_W-1:0] prev_accu_r;

  logic l2_hit_s;
  logic linf_hit_s;
  logic wrap_s;

  // Bound comparisons and accumulator wrap detection (all unsigned).
  always_comb begin
    l2_hit_s   = (accu_in > B22_V);
    linf_hit_s = (hoo_in > BOO_V);
    // The accumulator only grows within a run, so a drop means it wrapped.
    wrap_s     = (accu_in < prev_accu_r);
  end

  // Run sequencer with registered outputs and held verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      beat_cnt_r  <= '0;
      drain_cnt_r <= '0;
      prev_accu_r <= '0;
      stage_clr   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      l2_fail     <= 1'b0;
      linf_fail   <= 1'b0;
      ovf         <= 1'b0;
      proto_err   <= 1'b0;
      norm_q      <= '0;
    end else begin
      stage_clr <= 1'b0;
      done      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= CLEAR;
            stage_clr   <= 1'b1;
            busy        <= 1'b1;
            beat_cnt_r  <= '0;
            prev_accu_r <= '0;
            pass        <= 1'b0;
            l2_fail     <= 1'b0;
            linf_fail   <= 1'b0;
            ovf         <= 1'b0;
            proto_err   <= 1'b0;
            norm_q      <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        CLEAR: begin
          // A beat here is wiped by the clear, so it is flagged, not counted.
          if (in_flag) begin
            proto_err <= 1'b1;
          end
          state_r <= COLLECT;
        end
        COLLECT: begin
          prev_accu_r <= accu_in;
          if (wrap_s) begin
            ovf <= 1'b1;
          end
          if (in_flag) begin
            if (beat_cnt_r == LAST_BEAT) begin
              beat_cnt_r  <= '0;
              drain_cnt_r <= DRAIN_LOAD;
              state_r     <= DRAIN;
            end else begin
              beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          prev_accu_r <= accu_in;
          if (wrap_s) begin
            ovf <= 1'b1;
          end
          if (in_flag) begin
            proto_err <= 1'b1;
          end
          if (drain_cnt_r == '0) begin
            state_r <= CMP;
          end else begin
            drain_cnt_r <= drain_cnt_r - DRN_W'(1);
          end
        end
        CMP: begin
          norm_q    <= accu_in;
          l2_fail   <= l2_hit_s;
          linf_fail <= linf_hit_s;
          pass      <= !(l2_hit_s | linf_hit_s | ovf | proto_err);
          done      <= 1'b1;
          busy      <= 1'b0;
          state_r   <= DONE;
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_h_bound_judge.sv
// Testbench for h_bound_judge. A small environment model of the accumulator
// and sticky h stage feeds the DUT; each run's expected verdict is computed
// from the list of beats the accumulator actually absorbs.
module tb_h_bound_judge;

  localparam int N_BEATS   = 4;
  localparam int DRAIN_CYC = 3;
  localparam int ACC_W     = 15;
  localparam int B22       = 100;
  localparam int BOO       = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_flag;
  logic [ACC_W-1:0] accu_in;
  logic [1:0]       hoo_in;
  logic             stage_clr, busy, done, pass;
  logic             l2_fail, linf_fail, ovf, proto_err;
  logic [ACC_W-1:0] norm_q;

  logic [ACC_W-1:0] beat_inc;
  logic [1:0]       beat_h;

  int n_checks = 0;
  int n_fail   = 0;
  int incs[5];
  int hvs[5];

  always #5 clk = ~clk;

  h_bound_judge #(
    .N_BEATS(N_BEATS), .DRAIN_CYC(DRAIN_CYC), .ACC_W(ACC_W), .B22(B22), .BOO(BOO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_flag(in_flag),
    .accu_in(accu_in), .hoo_in(hoo_in),
    .stage_clr(stage_clr), .busy(busy), .done(done), .pass(pass),
    .l2_fail(l2_fail), .linf_fail(linf_fail), .ovf(ovf), .proto_err(proto_err),
    .norm_q(norm_q)
  );

  // Environment: wrapping accumulator (latency 1) and sticky h-stage maximum.
  always @(posedge clk) begin
    if (rst || stage_clr) begin
      accu_in <= '0;
      hoo_in  <= '0;
    end else if (in_flag) begin
      accu_in <= accu_in + beat_inc;
      if (beat_h > hoo_in) hoo_in <= beat_h;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stage_clr"}, 32'(stage_clr), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_pass"},      32'(pass),      32'd0);
    chk({tag, "_l2"},        32'(l2_fail),   32'd0);
    chk({tag, "_linf"},      32'(linf_fail), 32'd0);
    chk({tag, "_ovf"},       32'(ovf),       32'd0);
    chk({tag, "_proto"},     32'(proto_err), 32'd0);
    chk({tag, "_norm"},      32'(norm_q),    32'd0);
  endtask

  // One full signature run; inputs change and outputs are observed at negedge.
  task automatic run_sig(input bit clr_beat, input bit drain_beat,
                         input bit coll_start, input bit done_start);
    int sum, prev, hmax, nb, idx, clr_cnt, gaps;
    bit e_ovf, e_proto, e_l2, e_linf, e_pass;
    // Reference: the beats the accumulator absorbs, summed modulo 2^ACC_W.
    sum = 0; hmax = 0; e_ovf = 1'b0;
    nb = drain_beat ? 5 : 4;
    for (int i = 0; i < nb; i++) begin
      prev = sum;
      sum  = (sum + incs[i]) % (1 << ACC_W);
      if (sum < prev) e_ovf = 1'b1;
      if (hvs[i] > hmax) hmax = hvs[i];
    end
    e_l2    = (sum > B22);
    e_linf  = (hmax > BOO);
    e_proto = clr_beat | drain_beat;
    e_pass  = !(e_l2 | e_linf | e_ovf | e_proto);

    clr_cnt = 0;
    start = 1'b1; in_flag = 1'b0;
    @(negedge clk);
    chk("clr_pulse", 32'(stage_clr), 32'd1);
    chk("busy_clear", 32'(busy), 32'd1);
    clr_cnt += int'(stage_clr);
    start = 1'b0; in_flag = clr_beat;
    beat_inc = ACC_W'($urandom); beat_h = 2'($urandom);
    @(negedge clk);
    chk("clr_len", 32'(stage_clr), 32'd0);
    clr_cnt += int'(stage_clr);
    for (int b = 0; b < N_BEATS; b++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g <= gaps; g++) begin
        in_flag = (g == gaps);
        beat_inc = ACC_W'(incs[b]); beat_h = 2'(hvs[b]);
        start = coll_start && ($urandom_range(0, 1) == 1);
        @(negedge clk);
        clr_cnt += int'(stage_clr);
      end
    end
    // Now observing cycle f+1 (first DRAIN cycle).
    start = 1'b0; in_flag = drain_beat;
    beat_inc = ACC_W'(incs[4]); beat_h = 2'(hvs[4]);
    idx = 1;
    while (done !== 1'b1 && idx < 13) begin
      @(negedge clk);
      in_flag = 1'b0;
      idx++;
      clr_cnt += int'(stage_clr);
      if (idx == 4) chk("busy_cmp", 32'(busy), 32'd1);
    end
    chk("done_lat", 32'(idx), 32'd5);
    chk("busy_done", 32'(busy), 32'd0);
    chk("pass", 32'(pass), 32'(e_pass));
    chk("l2_fail", 32'(l2_fail), 32'(e_l2));
    chk("linf_fail", 32'(linf_fail), 32'(e_linf));
    chk("ovf", 32'(ovf), 32'(e_ovf));
    chk("proto_err", 32'(proto_err), 32'(e_proto));
    chk("norm_q", 32'(norm_q), 32'(sum));
    start = done_start;
    @(negedge clk);
    start = 1'b0;
    chk("done_len", 32'(done), 32'd0);
    chk("pass_held", 32'(pass), 32'(e_pass));
    chk("norm_held", 32'(norm_q), 32'(sum));
    clr_cnt += int'(stage_clr);
    @(negedge clk);
    chk("start_in_done_ignored", 32'(stage_clr), 32'd0);
    clr_cnt += int'(stage_clr);
    chk("clr_once", 32'(clr_cnt), 32'd1);
  endtask

  task automatic set_beats(input int a, input int b, input int c, input int d, input int e,
                           input int h0, input int h1, input int h2, input int h3, input int h4);
    incs[0] = a; incs[1] = b; incs[2] = c; incs[3] = d; incs[4] = e;
    hvs[0] = h0; hvs[1] = h1; hvs[2] = h2; hvs[3] = h3; hvs[4] = h4;
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1; start = 1'b0; in_flag = 1'b0; beat_inc = '0; beat_h = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed scenarios.
    set_beats(10, 10, 10, 10, 0, 1, 0, 1, 1, 0);   run_sig(0, 0, 0, 0);  // nominal, 40
    set_beats(25, 25, 25, 25, 0, 0, 1, 2, 0, 0);   run_sig(0, 0, 0, 0);  // L2 = 100 passes
    set_beats(25, 25, 25, 26, 0, 0, 1, 2, 0, 0);   run_sig(0, 0, 0, 0);  // L2 = 101 fails
    set_beats(5, 5, 5, 5, 0, 0, 3, 1, 0, 0);       run_sig(0, 0, 0, 0);  // Linf fail
    set_beats(32760, 7, 6, 0, 0, 1, 1, 1, 1, 0);   run_sig(0, 0, 0, 0);  // wrap to 5
    set_beats(10, 10, 10, 10, 0, 1, 1, 1, 1, 0);   run_sig(1, 0, 0, 0);  // beat in CLEAR
    set_beats(10, 10, 10, 10, 5, 1, 1, 1, 1, 1);   run_sig(0, 1, 0, 0);  // beat in DRAIN
    set_beats(10, 10, 10, 10, 0, 1, 1, 1, 1, 0);   run_sig(0, 0, 1, 1);  // start in COLLECT/DONE

    // Reset during DRAIN aborts the run.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int b = 0; b < N_BEATS; b++) begin
      in_flag = 1'b1; beat_inc = ACC_W'(7); beat_h = 2'd1;
      @(negedge clk);
    end
    in_flag = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("mid_reset");
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    chk("mid_reset_no_done", 32'(seen_done), 32'd0);
    set_beats(3, 4, 5, 6, 0, 1, 2, 0, 1, 0);       run_sig(0, 0, 0, 0);

    // Randomised runs.
    for (int r = 0; r < 24; r++) begin
      int mode;
      mode = $urandom_range(0, 3);
      for (int i = 0; i < 5; i++) begin
        incs[i] = (mode == 0) ? $urandom_range(10000, 20000) : $urandom_range(0, 35);
        hvs[i]  = ($urandom_range(0, 4) == 0) ? 3 : $urandom_range(0, 2);
      end
      run_sig($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
